// File: rtl/sys_ctrl_burst.sv
// Reference-domain frame controller: decodes RX command frames into register, ALU and
// burst accesses and streams response bytes to the TX FIFO under full-flag backpressure.
module sys_ctrl_burst #(
   parameter int unsigned BUS_WIDTH   = 8,
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned ALU_WIDTH   = 16,
   parameter int unsigned ALUFN_WIDTH = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [BUS_WIDTH-1:0]   RX_P_Data,
   input  logic                   RX_D_VLD,
   input  logic [BUS_WIDTH-1:0]   RdData,
   input  logic                   RdData_Valid,
   input  logic [ALU_WIDTH-1:0]   ALU_OUT,
   input  logic                   OUT_Valid,
   input  logic                   FIFO_FULL,
   output logic                   ALU_EN,
   output logic [ALUFN_WIDTH-1:0] ALU_FUN,
   output logic                   CLK_EN,
   output logic [ADDR_WIDTH-1:0]  Address,
   output logic                   WrEn,
   output logic                   RdEn,
   output logic [BUS_WIDTH-1:0]   WrData,
   output logic [BUS_WIDTH-1:0]   TX_P_Data,
   output logic                   TX_D_VLD,
   output logic                   o_busy,
   output logic                   o_frame_err
);

   localparam int unsigned NBYTES = ALU_WIDTH / BUS_WIDTH;
   localparam int unsigned NB_W   = $clog2(NBYTES + 1);

   localparam logic [BUS_WIDTH-1:0] CMD_WR_B  = BUS_WIDTH'(8'hAA);
   localparam logic [BUS_WIDTH-1:0] CMD_RD_B  = BUS_WIDTH'(8'hBB);
   localparam logic [BUS_WIDTH-1:0] CMD_ALU_B = BUS_WIDTH'(8'hCC);
   localparam logic [BUS_WIDTH-1:0] CMD_FUN_B = BUS_WIDTH'(8'hDD);
   localparam logic [BUS_WIDTH-1:0] CMD_BWR_B = BUS_WIDTH'(8'hEE);
   localparam logic [BUS_WIDTH-1:0] CMD_BRD_B = BUS_WIDTH'(8'hFF);

   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GET_CNT, GET_DATA, RD_ISSUE, RD_WAIT,
      OP_A, OP_B, GET_FUN, ALU_WAIT, TX_PUSH
   } state_e;

   typedef enum logic [2:0] {CMD_WR, CMD_RD, CMD_BWR, CMD_BRD, CMD_ALU} cmd_e;

   state_e                   state_q, state_d;
   cmd_e                     cmd_q, cmd_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [BUS_WIDTH-1:0]     cnt_q, cnt_d;
   logic [ALU_WIDTH-1:0]     tx_hold_q, tx_hold_d;
   logic [NB_W-1:0]          tx_left_q, tx_left_d;

   logic                     alu_en_d, clk_en_d, wr_en_d, rd_en_d, frame_err_d;
   logic [ALUFN_WIDTH-1:0]   alu_fun_d;
   logic [ADDR_WIDTH-1:0]    address_d;
   logic [BUS_WIDTH-1:0]     wr_data_d;

   // TX handshake follows the live full flag so a byte is never written into a full FIFO
   assign o_busy    = (state_q != IDLE);
   assign TX_D_VLD  = (state_q == TX_PUSH) && !FIFO_FULL;
   assign TX_P_Data = (state_q == TX_PUSH) ? tx_hold_q[BUS_WIDTH-1:0] : '0;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= IDLE;
         cmd_q       <= CMD_WR;
         addr_q      <= '0;
         cnt_q       <= '0;
         tx_hold_q   <= '0;
         tx_left_q   <= '0;
         ALU_EN      <= 1'b0;
         ALU_FUN     <= '0;
         CLK_EN      <= 1'b0;
         Address     <= '0;
         WrEn        <= 1'b0;
         RdEn        <= 1'b0;
         WrData      <= '0;
         o_frame_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         tx_hold_q   <= tx_hold_d;
         tx_left_q   <= tx_left_d;
         ALU_EN      <= alu_en_d;
         ALU_FUN     <= alu_fun_d;
         CLK_EN      <= clk_en_d;
         Address     <= address_d;
         WrEn        <= wr_en_d;
         RdEn        <= rd_en_d;
         WrData      <= wr_data_d;
         o_frame_err <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      tx_hold_d   = tx_hold_q;
      tx_left_d   = tx_left_q;
      alu_en_d    = 1'b0;
      alu_fun_d   = ALU_FUN;
      clk_en_d    = 1'b0;
      address_d   = Address;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      wr_data_d   = WrData;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (RX_D_VLD) begin
               case (RX_P_Data)
                  CMD_WR_B:  begin cmd_d = CMD_WR;  state_d = GET_ADDR; end
                  CMD_RD_B:  begin cmd_d = CMD_RD;  state_d = GET_ADDR; end
                  CMD_BWR_B: begin cmd_d = CMD_BWR; state_d = GET_ADDR; end
                  CMD_BRD_B: begin cmd_d = CMD_BRD; state_d = GET_ADDR; end
                  CMD_ALU_B: begin cmd_d = CMD_ALU; state_d = OP_A;     end
                  CMD_FUN_B: begin cmd_d = CMD_ALU; state_d = GET_FUN;  end
                  default:   frame_err_d = 1'b1;
               endcase
            end
         end
         GET_ADDR: begin
            if (RX_D_VLD) begin
               addr_d = RX_P_Data[ADDR_WIDTH-1:0];
               case (cmd_q)
                  CMD_WR:  begin cnt_d = BUS_WIDTH'(1); state_d = GET_DATA; end
                  CMD_RD:  begin cnt_d = BUS_WIDTH'(1); state_d = RD_ISSUE; end
                  default: state_d = GET_CNT;
               endcase
            end
         end
         GET_CNT: begin
            if (RX_D_VLD) begin
               if (RX_P_Data == '0) begin
                  frame_err_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  cnt_d   = RX_P_Data;
                  state_d = (cmd_q == CMD_BWR) ? GET_DATA : RD_ISSUE;
               end
            end
         end
         GET_DATA: begin
            if (RX_D_VLD) begin
               wr_en_d   = 1'b1;
               address_d = addr_q;
               wr_data_d = RX_P_Data;
               addr_d    = addr_q + ADDR_WIDTH'(1);
               cnt_d     = cnt_q - BUS_WIDTH'(1);
               if (cnt_q == BUS_WIDTH'(1)) state_d = IDLE;
            end
         end
         OP_A: begin
            if (RX_D_VLD) begin
               wr_en_d   = 1'b1;
               address_d = ADDR_WIDTH'(0);
               wr_data_d = RX_P_Data;
               state_d   = OP_B;
            end
         end
         OP_B: begin
            if (RX_D_VLD) begin
               wr_en_d   = 1'b1;
               address_d = ADDR_WIDTH'(1);
               wr_data_d = RX_P_Data;
               state_d   = GET_FUN;
            end
         end
         GET_FUN: begin
            if (RX_D_VLD) begin
               alu_fun_d = RX_P_Data[ALUFN_WIDTH-1:0];
               alu_en_d  = 1'b1;
               state_d   = ALU_WAIT;
            end
         end
         RD_ISSUE: begin
            frame_err_d = RX_D_VLD;
            state_d     = RD_WAIT;
         end
         RD_WAIT: begin
            frame_err_d = RX_D_VLD;
            if (RdData_Valid) begin
               tx_hold_d = ALU_WIDTH'(RdData);
               tx_left_d = NB_W'(1);
               state_d   = TX_PUSH;
            end
         end
         ALU_WAIT: begin
            frame_err_d = RX_D_VLD;
            if (OUT_Valid) begin
               tx_hold_d = ALU_OUT;
               tx_left_d = NB_W'(NBYTES);
               state_d   = TX_PUSH;
            end
         end
         TX_PUSH: begin
            frame_err_d = RX_D_VLD;
            // Bytes leave LSB first; the hold shifts down one byte per accepted write
            if (!FIFO_FULL) begin
               tx_hold_d = tx_hold_q >> BUS_WIDTH;
               tx_left_d = tx_left_q - NB_W'(1);
               if (tx_left_q == NB_W'(1)) begin
                  if (cmd_q == CMD_ALU) begin
                     state_d = IDLE;
                  end else begin
                     cnt_d   = cnt_q - BUS_WIDTH'(1);
                     state_d = (cnt_q == BUS_WIDTH'(1)) ? IDLE : RD_ISSUE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Every entry into RD_ISSUE fires one read at the current pointer and advances it
      if (state_d == RD_ISSUE && state_q != RD_ISSUE) begin
         rd_en_d   = 1'b1;
         address_d = addr_d;
         addr_d    = addr_d + ADDR_WIDTH'(1);
      end

      clk_en_d = (state_d == ALU_WAIT);
   end

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Directed bench for sys_ctrl_burst: frame table plus hand-written ALU, backpressure
// and reset sequences, with a small register-file responder.
module tb_sys_ctrl_burst;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  RX_P_Data;
   logic        RX_D_VLD;
   logic [7:0]  RdData;
   logic        RdData_Valid;
   logic [15:0] ALU_OUT;
   logic        OUT_Valid;
   logic        FIFO_FULL;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic        CLK_EN;
   logic [3:0]  Address;
   logic        WrEn;
   logic        RdEn;
   logic [7:0]  WrData;
   logic [7:0]  TX_P_Data;
   logic        TX_D_VLD;
   logic        o_busy;
   logic        o_frame_err;

   sys_ctrl_burst dut (
      .CLK(CLK), .RST(RST), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
      .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT),
      .OUT_Valid(OUT_Valid), .FIFO_FULL(FIFO_FULL), .ALU_EN(ALU_EN),
      .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN), .Address(Address), .WrEn(WrEn),
      .RdEn(RdEn), .WrData(WrData), .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD),
      .o_busy(o_busy), .o_frame_err(o_frame_err)
   );

   always #5 CLK = ~CLK;

   // Register file responder: read data one cycle after RdEn
   logic [7:0] mem [16];
   always @(posedge CLK) begin
      if (WrEn) mem[Address] <= WrData;
      RdData_Valid <= RdEn;
      if (RdEn) RdData <= mem[Address];
   end

   logic [11:0] wr_q[$];
   logic [7:0]  tx_q[$];
   int          err_cnt, alu_en_cnt, full_viol;
   int          tests = 0;
   int          fails = 0;

   always @(negedge CLK) begin
      if (WrEn) wr_q.push_back({Address, WrData});
      if (TX_D_VLD) tx_q.push_back(TX_P_Data);
      if (TX_D_VLD && FIFO_FULL) full_viol++;
      if (o_frame_err) err_cnt++;
      if (ALU_EN) alu_en_cnt++;
   end

   typedef struct packed {
      logic [47:0] rx;
      logic [3:0]  rx_n;
      logic [1:0]  wr_n;
      logic [35:0] wr;
      logic [1:0]  tx_n;
      logic [23:0] tx;
      logic [1:0]  err_n;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_obs();
      wr_q.delete();
      tx_q.delete();
      err_cnt    = 0;
      alu_en_cnt = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLK); #1;
      RX_P_Data = b;
      RX_D_VLD  = 1'b1;
      @(posedge CLK); #1;
      RX_D_VLD  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (!o_busy) break;
      end
      check({name, "_idle"}, 64'(o_busy), 64'(0));
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      string nm;
      logic [11:0] got_w;
      logic [7:0]  got_t;

      // {rx bytes LSB-first, count, writes {addr,data} LSB-first, tx bytes, errors}
      vecs[0] = '{rx: 48'h3C05AA,       rx_n: 4'd3, wr_n: 2'd1, wr: 36'h00000053C, tx_n: 2'd0, tx: 24'h0,      err_n: 2'd0};
      vecs[1] = '{rx: 48'h05BB,         rx_n: 4'd2, wr_n: 2'd0, wr: 36'h0,         tx_n: 2'd1, tx: 24'h00003C, err_n: 2'd0};
      vecs[2] = '{rx: 48'h332211030EEE, rx_n: 4'd6, wr_n: 2'd3, wr: 36'h033F22E11, tx_n: 2'd0, tx: 24'h0,      err_n: 2'd0};
      vecs[3] = '{rx: 48'h030EFF,       rx_n: 4'd3, wr_n: 2'd0, wr: 36'h0,         tx_n: 2'd3, tx: 24'h332211, err_n: 2'd0};
      vecs[4] = '{rx: 48'h42,           rx_n: 4'd1, wr_n: 2'd0, wr: 36'h0,         tx_n: 2'd0, tx: 24'h0,      err_n: 2'd1};
      vecs[5] = '{rx: 48'h0003EE,       rx_n: 4'd3, wr_n: 2'd0, wr: 36'h0,         tx_n: 2'd0, tx: 24'h0,      err_n: 2'd1};
      vecs[6] = '{rx: 48'h0007FF,       rx_n: 4'd3, wr_n: 2'd0, wr: 36'h0,         tx_n: 2'd0, tx: 24'h0,      err_n: 2'd1};
      vecs[7] = '{rx: 48'h5A1FAA,       rx_n: 4'd3, wr_n: 2'd1, wr: 36'h000000F5A, tx_n: 2'd0, tx: 24'h0,      err_n: 2'd0};
      vecs[8] = '{rx: 48'h020FFF,       rx_n: 4'd3, wr_n: 2'd0, wr: 36'h0,         tx_n: 2'd2, tx: 24'h00335A, err_n: 2'd0};
      vecs[9] = '{rx: 48'h3EBB,         rx_n: 4'd2, wr_n: 2'd0, wr: 36'h0,         tx_n: 2'd1, tx: 24'h000011, err_n: 2'd0};

      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      RST = 1'b0; RX_P_Data = 8'h00; RX_D_VLD = 1'b0; ALU_OUT = 16'h0;
      OUT_Valid = 1'b0; FIFO_FULL = 1'b0; full_viol = 0;
      clear_obs();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("reset_outputs",
            64'({ALU_EN, ALU_FUN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_Data, TX_D_VLD, o_busy, o_frame_err}),
            64'(0));
      @(posedge CLK); #1; RST = 1'b1;

      // Frame table
      for (int k = 0; k < 10; k++) begin
         v = vecs[k];
         clear_obs();
         for (int i = 0; i < int'(v.rx_n); i++) send_byte(v.rx[8*i +: 8]);
         wait_idle($sformatf("v%0d", k));
         check($sformatf("v%0d_wr_count", k), 64'(wr_q.size()), 64'(v.wr_n));
         for (int i = 0; i < int'(v.wr_n); i++) begin
            got_w = (i < wr_q.size()) ? wr_q[i] : 12'hFFF;
            check($sformatf("v%0d_wr%0d", k, i), 64'(got_w), 64'(v.wr[12*i +: 12]));
         end
         check($sformatf("v%0d_tx_count", k), 64'(tx_q.size()), 64'(v.tx_n));
         for (int i = 0; i < int'(v.tx_n); i++) begin
            got_t = (i < tx_q.size()) ? tx_q[i] : 8'hFF;
            check($sformatf("v%0d_tx%0d", k, i), 64'(got_t), 64'(v.tx[8*i +: 8]));
         end
         check($sformatf("v%0d_err", k), 64'(err_cnt), 64'(v.err_n));
      end

      // ALU with operands: reg0/reg1 writes, start pulse, two response bytes LSB first
      clear_obs();
      send_byte(8'hCC); send_byte(8'h10); send_byte(8'h20); send_byte(8'h04);
      @(negedge CLK);
      check("alu_en_pulse", 64'(ALU_EN), 64'(1));
      check("alu_fun", 64'(ALU_FUN), 64'(4));
      check("clk_en_on", 64'(CLK_EN), 64'(1));
      @(negedge CLK);
      check("alu_en_once", 64'(ALU_EN), 64'(0));
      check("clk_en_hold", 64'(CLK_EN), 64'(1));
      repeat (3) @(negedge CLK);
      check("alu_wait_busy", 64'(o_busy), 64'(1));
      check("alu_wait_no_tx", 64'(tx_q.size()), 64'(0));
      @(posedge CLK); #1; ALU_OUT = 16'h0030; OUT_Valid = 1'b1;
      @(posedge CLK); #1; OUT_Valid = 1'b0;
      @(negedge CLK);
      check("alu_tx0_vld", 64'(TX_D_VLD), 64'(1));
      check("alu_tx0_data", 64'(TX_P_Data), 64'(8'h30));
      check("clk_en_off", 64'(CLK_EN), 64'(0));
      @(negedge CLK);
      check("alu_tx1_vld", 64'(TX_D_VLD), 64'(1));
      check("alu_tx1_data", 64'(TX_P_Data), 64'(8'h00));
      @(negedge CLK);
      check("alu_tx_done", 64'(TX_D_VLD), 64'(0));
      check("alu_idle", 64'(o_busy), 64'(0));
      check("alu_wr_count", 64'(wr_q.size()), 64'(2));
      check("alu_wr_a", 64'(wr_q[0]), 64'(12'h010));
      check("alu_wr_b", 64'(wr_q[1]), 64'(12'h120));
      check("alu_en_count", 64'(alu_en_cnt), 64'(1));

      // ALU without operands
      clear_obs();
      send_byte(8'hDD); send_byte(8'h02);
      @(negedge CLK);
      check("dd_alu_fun", 64'(ALU_FUN), 64'(2));
      @(posedge CLK); #1; ALU_OUT = 16'hBEEF; OUT_Valid = 1'b1;
      @(posedge CLK); #1; OUT_Valid = 1'b0;
      wait_idle("dd");
      check("dd_tx_count", 64'(tx_q.size()), 64'(2));
      check("dd_tx0", 64'(tx_q[0]), 64'(8'hEF));
      check("dd_tx1", 64'(tx_q[1]), 64'(8'hBE));
      check("dd_no_wr", 64'(wr_q.size()), 64'(0));

      // Burst read of 2 against a full FIFO, plus a stray byte while pushing
      clear_obs();
      FIFO_FULL = 1'b1;
      send_byte(8'hFF); send_byte(8'h0E); send_byte(8'h02);
      repeat (5) @(negedge CLK);
      send_byte(8'h55);
      repeat (2) @(negedge CLK);
      check("full_no_tx", 64'(tx_q.size()), 64'(0));
      check("full_busy", 64'(o_busy), 64'(1));
      @(posedge CLK); #1; FIFO_FULL = 1'b0;
      wait_idle("full");
      check("full_tx_count", 64'(tx_q.size()), 64'(2));
      check("full_tx0", 64'(tx_q[0]), 64'(8'h11));
      check("full_tx1", 64'(tx_q[1]), 64'(8'h5A));
      check("stray_err", 64'(err_cnt), 64'(1));

      // Reset while waiting on the ALU
      clear_obs();
      send_byte(8'hDD); send_byte(8'h03);
      repeat (2) @(negedge CLK);
      check("rst_pre_clk_en", 64'(CLK_EN), 64'(1));
      @(posedge CLK); #1; RST = 1'b0;
      @(posedge CLK); #1; RST = 1'b1; ALU_OUT = 16'h1234; OUT_Valid = 1'b1;
      @(negedge CLK);
      check("rst_outputs",
            64'({ALU_EN, ALU_FUN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_Data, TX_D_VLD, o_busy, o_frame_err}),
            64'(0));
      @(posedge CLK); #1; OUT_Valid = 1'b0;
      repeat (5) @(negedge CLK);
      check("rst_no_tx", 64'(tx_q.size()), 64'(0));
      check("rst_idle", 64'(o_busy), 64'(0));

      check("tx_while_full", 64'(full_viol), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
